bram_ctrl: RTL and testbench
============================

# bram_ctrl

CPU-side memory controller that sits directly upstream of the on-chip block RAM. It accepts one byte-addressed load/store request at a time over a valid/ready handshake and drives the RAM's word-wide read/write strobes. It performs read-modify-write for partial-word stores, since the RAM has no byte enables. It returns a single-cycle response pulse carrying read data and an error flag for out-of-range accesses.

## Interface
- DEPTH, 16384, number of 32-bit words in the attached RAM
- AW, 16, word-address width of the RAM port; the byte address is AW+2 bits
- clk  in  1  single clock, rising edge
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  controller can accept; a request transfers on a clk edge where req_valid && req_ready
- req_write  in  1  1 = store, 0 = load
- req_addr  in  AW+2  byte address; word address = req_addr[AW+1:2]; bits [1:0] ignored
- req_wdata  in  32  store data, lane-aligned (byte n in bits 8n+7:8n)
- req_be  in  4  store byte enables; ignored for loads
- resp_valid  out  1  one-cycle completion pulse; no backpressure
- resp_rdata  out  32  load data; 0 for stores and errors
- resp_err  out  1  word address >= DEPTH
- mem_rd_en  out  1  RAM read strobe
- mem_wr_en  out  1  RAM write strobe
- mem_addr  out  AW  RAM word address
- mem_wdata  out  32  RAM write data
- mem_rdata  in  32  RAM registered read data, valid the cycle after the mem_rd_en cycle

## Operation
- States: IDLE, RD, RD_WAIT, WR, RMW_RD, RMW_WAIT, RMW_WR, RESP.
- req_ready = 1 only in IDLE. Exactly one request is outstanding at a time.
- All mem_* and resp_* outputs are registered. mem_rd_en and mem_wr_en are never both 1. Each strobe is high for exactly one cycle per access.
- Accept in IDLE: the controller latches addr, wdata, be and write, then classifies the request:
  - word address >= DEPTH: no RAM access; go to RESP with err=1 and rdata=0.
  - load: go to RD. RD drives mem_rd_en=1 and mem_addr. RD_WAIT captures mem_rdata into resp_rdata. Then RESP.
  - store, be=4'hF: go to WR. WR drives mem_wr_en=1, mem_addr and mem_wdata=req_wdata. Then RESP.
  - store, be=4'h0: no RAM access; go to RESP with err=0.
  - store, other be: RMW_RD issues the read. RMW_WAIT computes the merged word: byte n = be[n] ? wdata byte n : mem_rdata byte n. The merged word is registered into mem_wdata. RMW_WR drives mem_wr_en=1. Then RESP.
- RESP: resp_valid=1 for one cycle, then IDLE.
- mem_addr and mem_wdata hold their last value when no strobe is active. The RAM ignores them in that case.

## Timing
- Let A be the cycle in which the handshake occurs. resp_valid is high in:
  - A+3 for a load (mem_rd_en in A+1, mem_rdata valid in A+2);
  - A+2 for a full-word store (mem_wr_en in A+1);
  - A+4 for a partial store (mem_rd_en in A+1, mem_wr_en in A+3);
  - A+1 for an error or a be=0 store.
- The next request can be accepted in the cycle after the resp_valid cycle. Back-to-back full stores therefore take 3 cycles each.
- Reset: on any clk edge with rst=1:
  - state goes to IDLE;
  - req_ready=0 during reset and 1 in the first cycle after rst drops;
  - resp_valid=0, resp_err=0, resp_rdata=0;
  - mem_rd_en=0, mem_wr_en=0, mem_addr=0, mem_wdata=0.
- Reset mid-operation aborts the operation without a response. No strobe is issued after the reset edge, including a partially completed RMW. The pending write is dropped, and RAM content for that word keeps its pre-request value.
- req_valid with rst=1 is not accepted.
- Requests presented while req_ready=0 are not consumed. The requester must hold them until the handshake occurs.

## Test plan
- Reset, then full store addr=0x0010, wdata=0xDEADBEEF, be=F; then load 0x0010. Required: mem_wr_en in A+1 with mem_addr=4 and store resp in A+2; load resp in A+3 with rdata=0xDEADBEEF, err=0.
- Word 4 = 0xDEADBEEF. Partial store addr=0x0012, be=4'b0100, wdata=0x00AA0000. Required: mem_rd_en in A+1, mem_wr_en in A+3 with mem_wdata=0xDEAABEEF; a subsequent load of word 4 returns 0xDEAABEEF.
- Load at byte addr 4*DEPTH. Required: no strobes; resp_valid in A+1 with err=1, rdata=0. Repeat as a store: same response, and RAM is unchanged.
- Store with be=0. Required: no strobes; resp in A+1 with err=0.
- Assert rst during RMW_WAIT of a partial store. Required: mem_wr_en stays 0, no resp_valid, req_ready=1 in the cycle after rst drops; a load of the word returns its old value.
- req_valid held high continuously with alternating load/store. Required: exactly one handshake per response, strobes never overlap, and resp latencies match the Timing section.

Source files
------------

// File: rtl/bram_ctrl.sv
// bram_ctrl: one-outstanding byte-addressed load/store front end for a word-wide block RAM.
// Partial-word stores become read-modify-write because the RAM has no byte enables.
module bram_ctrl #(
    parameter int DEPTH = 16384,
    parameter int AW    = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_write,
    input  logic [AW+1:0] req_addr,
    input  logic [31:0]   req_wdata,
    input  logic [3:0]    req_be,
    output logic          resp_valid,
    output logic [31:0]   resp_rdata,
    output logic          resp_err,
    output logic          mem_rd_en,
    output logic          mem_wr_en,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);

    // state    | meaning
    // IDLE     | waiting for a request, req_ready high
    // RD       | load read strobe on the RAM port
    // RD_WAIT  | RAM read data valid, captured into resp_rdata
    // WR       | full-word store write strobe
    // RMW_RD   | partial store, read of the old word
    // RMW_WAIT | old word valid, merged word registered into mem_wdata
    // RMW_WR   | partial store, write strobe of the merged word
    // RESP     | one-cycle response pulse
    typedef enum logic [2:0] {
        IDLE, RD, RD_WAIT, WR, RMW_RD, RMW_WAIT, RMW_WR, RESP
    } state_t;

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    state_t        state;
    state_t        state_nx;

    logic [AW-1:0] req_word;
    logic          req_oor;
    logic          req_fire;
    logic [31:0]   wdata_q;
    logic [3:0]    be_q;
    logic [31:0]   merged;

    logic          rd_en_d;
    logic          wr_en_d;
    logic          resp_valid_d;
    logic          resp_err_d;
    logic [31:0]   resp_rdata_d;
    logic [AW-1:0] mem_addr_d;
    logic [31:0]   mem_wdata_d;

    // Byte-lane bits of the address do not select anything on a word-wide RAM.
    logic          unused_addr_lsb;
    assign unused_addr_lsb = ^req_addr[1:0];

    assign req_word  = req_addr[AW+1:2];
    assign req_oor   = ({1'b0, req_word} >= DEPTH_W);
    assign req_ready = (state == IDLE) && !rst;
    assign req_fire  = req_valid && req_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (req_fire) begin
                    if (req_oor) begin
                        state_nx = RESP;
                    end else if (!req_write) begin
                        state_nx = RD;
                    end else if (req_be == 4'hF) begin
                        state_nx = WR;
                    end else if (req_be == 4'h0) begin
                        state_nx = RESP;
                    end else begin
                        state_nx = RMW_RD;
                    end
                end
            end
            RD:       state_nx = RD_WAIT;
            RD_WAIT:  state_nx = RESP;
            WR:       state_nx = RESP;
            RMW_RD:   state_nx = RMW_WAIT;
            RMW_WAIT: state_nx = RMW_WR;
            RMW_WR:   state_nx = RESP;
            RESP:     state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    always_comb begin
        merged = mem_rdata;
        for (int n = 0; n < 4; n++) begin
            if (be_q[n]) begin
                merged[8*n +: 8] = wdata_q[8*n +: 8];
            end
        end
    end

    // Outputs are decoded from the next state so the registered strobes line up with it.
    always_comb begin
        rd_en_d      = (state_nx == RD) || (state_nx == RMW_RD);
        wr_en_d      = (state_nx == WR) || (state_nx == RMW_WR);
        resp_valid_d = (state_nx == RESP);
        resp_err_d   = (state == IDLE) && req_fire && req_oor;
        resp_rdata_d = (state == RD_WAIT) ? mem_rdata : 32'h0;
        mem_addr_d   = mem_addr;
        mem_wdata_d  = mem_wdata;
        if ((state == IDLE) && (rd_en_d || wr_en_d)) begin
            mem_addr_d = req_word;
        end
        if (state_nx == WR) begin
            mem_wdata_d = req_wdata;
        end else if (state_nx == RMW_WR) begin
            mem_wdata_d = merged;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wdata_q <= 32'h0;
            be_q    <= 4'h0;
        end else if (req_fire) begin
            wdata_q <= req_wdata;
            be_q    <= req_be;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_rd_en  <= 1'b0;
            mem_wr_en  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= 32'h0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'h0;
        end else begin
            mem_rd_en  <= rd_en_d;
            mem_wr_en  <= wr_en_d;
            mem_addr   <= mem_addr_d;
            mem_wdata  <= mem_wdata_d;
            resp_valid <= resp_valid_d;
            resp_err   <= resp_err_d;
            resp_rdata <= resp_rdata_d;
        end
    end

endmodule

// File: tb/tb_bram_ctrl.sv
// tb_bram_ctrl: directed vector bench for bram_ctrl with a behavioural RAM behind the mem_* port.
// Unwritten RAM words read as {16'hA5A5, word_address}.
module tb_bram_ctrl;

    localparam int DEPTH = 16384;
    localparam int AW    = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [AW+1:0] req_addr = '0;
    logic [31:0]   req_wdata = 32'h0;
    logic [3:0]    req_be = 4'h0;
    logic          resp_valid;
    logic [31:0]   resp_rdata;
    logic          resp_err;
    logic          mem_rd_en;
    logic          mem_wr_en;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    bram_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    logic [31:0] ram [int];
    logic [31:0] ram_q = 32'h0;
    assign mem_rdata = ram_q;

    always @(posedge clk) begin
        if (mem_rd_en) begin
            ram_q <= ram.exists(int'(mem_addr)) ? ram[int'(mem_addr)] : {16'hA5A5, mem_addr};
        end
        if (mem_wr_en) begin
            ram[int'(mem_addr)] = mem_wdata;
        end
    end

    typedef struct {
        logic        write;
        logic [17:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          lat;
        logic [31:0] rdata;
        logic        err;
        int          rd_at;
        int          wr_at;
        logic [15:0] maddr;
        logic [31:0] mwdata;
    } vec_t;

    vec_t vecs[13];
    vec_t bb[6];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic present(input vec_t v);
        req_write = v.write;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        req_be    = v.be;
        req_valid = 1'b1;
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        int g = 0;
        int lat = 0;
        int rd_cnt = 0;
        int wr_cnt = 0;
        int rd_at = 0;
        int wr_at = 0;
        int ovl = 0;
        int busy_rdy = 0;
        logic [15:0] rd_a = '0;
        logic [15:0] wr_a = '0;
        logic [31:0] wr_d = '0;
        logic [31:0] rdat = '0;
        logic        err = 1'b0;
        present(v);
        while (!req_ready && g < 20) begin
            @(negedge clk);
            g++;
        end
        chk({nm, "_accept"}, 32'(req_ready), 32'(1));
        @(negedge clk);
        req_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            if (mem_rd_en) begin rd_cnt++; if (rd_at == 0) rd_at = k; rd_a = mem_addr; end
            if (mem_wr_en) begin wr_cnt++; if (wr_at == 0) wr_at = k; wr_a = mem_addr; wr_d = mem_wdata; end
            if (mem_rd_en && mem_wr_en) ovl++;
            if (req_ready) busy_rdy++;
            if (resp_valid) begin lat = k; rdat = resp_rdata; err = resp_err; break; end
            @(negedge clk);
        end
        chk({nm, "_latency"}, 32'(lat), 32'(v.lat));
        chk({nm, "_rdata"}, rdat, v.rdata);
        chk({nm, "_err"}, 32'(err), 32'(v.err));
        chk({nm, "_rd_count"}, 32'(rd_cnt), 32'(v.rd_at != 0));
        chk({nm, "_rd_cycle"}, 32'(rd_at), 32'(v.rd_at));
        chk({nm, "_wr_count"}, 32'(wr_cnt), 32'(v.wr_at != 0));
        chk({nm, "_wr_cycle"}, 32'(wr_at), 32'(v.wr_at));
        chk({nm, "_overlap"}, 32'(ovl), 32'(0));
        chk({nm, "_ready_busy"}, 32'(busy_rdy), 32'(0));
        if (v.rd_at != 0) chk({nm, "_rd_addr"}, 32'(rd_a), 32'(v.maddr));
        if (v.wr_at != 0) begin
            chk({nm, "_wr_addr"}, 32'(wr_a), 32'(v.maddr));
            chk({nm, "_wr_data"}, wr_d, v.mwdata);
        end
        @(negedge clk);
        chk({nm, "_ready_after"}, 32'(req_ready), 32'(1));
        chk({nm, "_resp_single"}, 32'(resp_valid), 32'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, hs, rs, ni, ovl_b, rst_seen;
        int hs_cyc[6];
        logic adv;

        //          wr    addr       wdata         be    lat rdata         err  rd wr maddr     mwdata
        vecs[0]  = '{1'b1, 18'h00010, 32'hDEADBEEF, 4'hF, 2, 32'h0,        1'b0, 0, 1, 16'h0004, 32'hDEADBEEF};
        vecs[1]  = '{1'b0, 18'h00010, 32'h0,        4'h0, 3, 32'hDEADBEEF, 1'b0, 1, 0, 16'h0004, 32'h0};
        vecs[2]  = '{1'b1, 18'h00012, 32'h00AA0000, 4'h4, 4, 32'h0,        1'b0, 1, 3, 16'h0004, 32'hDEAABEEF};
        vecs[3]  = '{1'b0, 18'h00013, 32'h0,        4'hF, 3, 32'hDEAABEEF, 1'b0, 1, 0, 16'h0004, 32'h0};
        vecs[4]  = '{1'b0, 18'h10000, 32'h0,        4'h0, 1, 32'h0,        1'b1, 0, 0, 16'h0000, 32'h0};
        vecs[5]  = '{1'b1, 18'h10000, 32'h12345678, 4'hF, 1, 32'h0,        1'b1, 0, 0, 16'h0000, 32'h0};
        vecs[6]  = '{1'b0, 18'h00010, 32'h0,        4'h0, 3, 32'hDEAABEEF, 1'b0, 1, 0, 16'h0004, 32'h0};
        vecs[7]  = '{1'b1, 18'h00020, 32'hFFFFFFFF, 4'h0, 1, 32'h0,        1'b0, 0, 0, 16'h0000, 32'h0};
        vecs[8]  = '{1'b0, 18'h00020, 32'h0,        4'h0, 3, 32'hA5A50008, 1'b0, 1, 0, 16'h0008, 32'h0};
        vecs[9]  = '{1'b1, 18'h0001C, 32'h11223344, 4'h9, 4, 32'h0,        1'b0, 1, 3, 16'h0007, 32'h11A50044};
        vecs[10] = '{1'b0, 18'h0001C, 32'h0,        4'h0, 3, 32'h11A50044, 1'b0, 1, 0, 16'h0007, 32'h0};
        vecs[11] = '{1'b0, 18'h0FFFC, 32'h0,        4'h0, 3, 32'hA5A53FFF, 1'b0, 1, 0, 16'h3FFF, 32'h0};
        vecs[12] = '{1'b0, 18'h3FFFC, 32'h0,        4'h0, 1, 32'h0,        1'b1, 0, 0, 16'h0000, 32'h0};

        bb[0] = '{1'b1, 18'h00028, 32'hCAFEF00D, 4'hF, 2, 32'h0,        1'b0, 0, 1, 16'h000A, 32'hCAFEF00D};
        bb[1] = '{1'b0, 18'h00028, 32'h0,        4'h0, 3, 32'hCAFEF00D, 1'b0, 1, 0, 16'h000A, 32'h0};
        bb[2] = '{1'b1, 18'h00028, 32'h00001234, 4'h3, 4, 32'h0,        1'b0, 1, 3, 16'h000A, 32'hCAFE1234};
        bb[3] = '{1'b0, 18'h0002A, 32'h0,        4'h0, 3, 32'hCAFE1234, 1'b0, 1, 0, 16'h000A, 32'h0};
        bb[4] = '{1'b1, 18'h0002C, 32'h55555555, 4'h0, 1, 32'h0,        1'b0, 0, 0, 16'h0000, 32'h0};
        bb[5] = '{1'b0, 18'h10000, 32'h0,        4'h0, 1, 32'h0,        1'b1, 0, 0, 16'h0000, 32'h0};

        // Reset state, with a request already offered while rst is high.
        req_valid = 1'b1;
        req_write = 1'b1;
        req_be    = 4'hF;
        req_wdata = 32'h0BADF00D;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'(0));
        chk("rst_resp_valid", 32'(resp_valid), 32'(0));
        chk("rst_resp_err", 32'(resp_err), 32'(0));
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        chk("rst_mem_rd_en", 32'(mem_rd_en), 32'(0));
        chk("rst_mem_wr_en", 32'(mem_wr_en), 32'(0));
        chk("rst_mem_addr", 32'(mem_addr), 32'(0));
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        req_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("rst_ready_after_release", 32'(req_ready), 32'(1));

        for (int i = 0; i < 13; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset while the partial store sits in RMW_WAIT: the write must be dropped.
        present('{1'b1, 18'h00024, 32'h0000BB00, 4'h2, 0, 32'h0, 1'b0, 0, 0, 16'h0, 32'h0});
        chk("rmw_rst_accept", 32'(req_ready), 32'(1));
        @(negedge clk);
        req_valid = 1'b0;
        chk("rmw_rst_rd_strobe", 32'(mem_rd_en), 32'(1));
        @(negedge clk);
        rst = 1'b1;
        rst_seen = 0;
        @(negedge clk);
        chk("rmw_rst_ready_in_rst", 32'(req_ready), 32'(0));
        if (mem_wr_en || resp_valid) rst_seen++;
        @(negedge clk);
        if (mem_wr_en || resp_valid) rst_seen++;
        rst = 1'b0;
        #1;
        chk("rmw_rst_ready_after", 32'(req_ready), 32'(1));
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (mem_wr_en || resp_valid) rst_seen++;
        end
        chk("rmw_rst_no_wr_no_resp", 32'(rst_seen), 32'(0));
        run_vec('{1'b0, 18'h00024, 32'h0, 4'h0, 3, 32'hA5A50009, 1'b0, 1, 0, 16'h0009, 32'h0}, "rmw_rst_reload");

        // req_valid held high across alternating loads and stores.
        cyc = 0; hs = 0; rs = 0; ni = 1; ovl_b = 0; adv = 1'b0;
        present(bb[0]);
        while (rs < 6 && cyc < 200) begin
            if (mem_rd_en && mem_wr_en) ovl_b++;
            if (resp_valid) begin
                if (rs < hs) begin
                    chk($sformatf("b2b%0d_latency", rs), 32'(cyc - hs_cyc[rs]), 32'(bb[rs].lat));
                    chk($sformatf("b2b%0d_rdata", rs), resp_rdata, bb[rs].rdata);
                    chk($sformatf("b2b%0d_err", rs), 32'(resp_err), 32'(bb[rs].err));
                end else begin
                    chk("b2b_resp_without_req", 32'(rs), 32'(hs));
                end
                rs++;
            end
            if (adv) begin
                adv = 1'b0;
                if (ni < 6) begin
                    present(bb[ni]);
                    ni++;
                end else begin
                    req_valid = 1'b0;
                end
            end
            if (req_valid && req_ready && hs < 6) begin
                chk("b2b_outstanding", 32'(hs), 32'(rs));
                hs_cyc[hs] = cyc;
                hs++;
                adv = 1'b1;
            end
            @(negedge clk);
            cyc++;
        end
        req_valid = 1'b0;
        chk("b2b_handshakes", 32'(hs), 32'(6));
        chk("b2b_responses", 32'(rs), 32'(6));
        chk("b2b_overlap", 32'(ovl_b), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
